// File: rtl/wb_initiator_if.sv
// wb_initiator_if: Wishbone classic master-side bus bundle
// Ports (as signals): wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o[3:0], wbm_adr_o[31:0],
// wbm_dat_o[31:0] driven by the master; wbm_ack_i, wbm_dat_i[31:0] driven by the slave.
interface wb_initiator_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );
    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding command/response to Wishbone classic master bridge with ack timeout
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; cmd_valid/cmd_ready/cmd_we/cmd_sel/
// cmd_adr/cmd_dat command channel; rsp_valid/rsp_ready/rsp_dat/rsp_err response channel;
// busy high outside IDLE; wb is the Wishbone master bundle.
module wb_initiator #(
    parameter int TIMEOUT = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    wb_initiator_if.master wb
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic take, done, abort;
    // ack wins over timeout on the same edge
    always_comb begin
        take = (state == IDLE) && cmd_valid;
        done = (state == BUS) && wb.wbm_ack_i;
        abort = (state == BUS) && !wb.wbm_ack_i && (cnt == 8'(TIMEOUT));
        state_nxt = take ? BUS : (done || abort) ? RESP : (state == RESP && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt <= '0;
            wb.wbm_we_o <= 1'b0;
            wb.wbm_sel_o <= '0;
            wb.wbm_adr_o <= '0;
            wb.wbm_dat_o <= '0;
            rsp_dat <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                wb.wbm_we_o <= cmd_we;
                wb.wbm_sel_o <= cmd_sel;
                wb.wbm_adr_o <= cmd_adr;
                wb.wbm_dat_o <= cmd_dat;
                cnt <= 8'd1;
            end else if (state == BUS) begin
                if (done || abort) begin
                    rsp_dat <= (done && !wb.wbm_we_o) ? wb.wbm_dat_i : '0;
                    rsp_err <= abort;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
    // cyc/stb and handshakes decode from state so reset drops them immediately
    assign wb.wbm_cyc_o = (state == BUS);
    assign wb.wbm_stb_o = (state == BUS);
    assign rsp_valid = (state == RESP);
    assign cmd_ready = (state == IDLE);
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: table-driven check of wb_initiator transactions, timeout, backpressure and reset
module tb_wb_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    int total = 0;
    int bad = 0;
    wb_initiator_if bus();
    wb_initiator #(.TIMEOUT(64)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .busy(busy), .wb(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          ack_at;
        logic [31:0] rdata;
        int          hold;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;
    vec_t v[7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic run(input vec_t t);
        int n;
        bit stable;
        cmd_valid = 1'b1;
        cmd_we = t.we;
        cmd_sel = t.sel;
        cmd_adr = t.adr;
        cmd_dat = t.dat;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        stable = 1'b1;
        while (bus.wbm_cyc_o && n < 300) begin
            n++;
            if (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== t.we || bus.wbm_sel_o !== t.sel ||
                bus.wbm_adr_o !== t.adr || bus.wbm_dat_o !== t.dat || cmd_ready !== 1'b0 ||
                busy !== 1'b1 || rsp_valid !== 1'b0)
                stable = 1'b0;
            bus.wbm_ack_i = (n == t.ack_at);
            bus.wbm_dat_i = bus.wbm_ack_i ? t.rdata : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        bus.wbm_ack_i = 1'b0;
        chk("cyc_cycles", 32'(n), 32'(t.exp_cyc));
        chk("bus_stable", 32'(stable), 32'd1);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_dat", rsp_dat, t.exp_dat);
        chk("rsp_err", 32'(rsp_err), 32'(t.exp_err));
        stable = 1'b1;
        for (int i = 0; i < t.hold; i++) begin
            cmd_valid = 1'b1;
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = 32'h5555_AAAA;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== t.exp_dat || rsp_err !== t.exp_err ||
                cmd_ready !== 1'b0 || bus.wbm_cyc_o !== 1'b0)
                stable = 1'b0;
        end
        bus.wbm_ack_i = 1'b0;
        if (t.hold > 0) chk("resp_hold_stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        v[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A, 12, 32'h0BAD_0BAD, 0, 32'h0, 1'b0, 12};
        v[1] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0, 1, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1};
        v[2] = '{1'b0, 4'hF, 32'h3800_0020, 32'h0, 0, 32'h0, 6, 32'h0, 1'b1, 64};
        v[3] = '{1'b0, 4'hF, 32'h3800_0030, 32'h0, 64, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 64};
        v[4] = '{1'b1, 4'h0, 32'h1000_0000, 32'h1111_2222, 3, 32'h7777_7777, 0, 32'h0, 1'b0, 3};
        v[5] = '{1'b0, 4'h3, 32'h2000_0008, 32'h0, 2, 32'h0000_BEEF, 20, 32'h0000_BEEF, 1'b0, 2};
        v[6] = '{1'b0, 4'hC, 32'h2000_000C, 32'h0, 1, 32'h8765_4321, 0, 32'h8765_4321, 1'b0, 1};
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
        chk("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
        chk("rst_adr", bus.wbm_adr_o, 32'd0);
        chk("rst_dat", bus.wbm_dat_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_release", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 7; i++) run(v[i]);
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_sel = 4'hF;
        cmd_adr = 32'h3800_0040;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midbus_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("async_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midbus_no_rsp", 32'(rsp_valid), 32'd0);
        chk("midbus_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midbus_adr_clr", bus.wbm_adr_o, 32'd0);
        cmd_valid = 1'b1;
        cmd_adr = 32'h3800_0050;
        @(negedge clk);
        cmd_valid = 1'b0;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h4242_4242;
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        chk("resp_before_rst", 32'(rsp_valid), 32'd1);
        chk("resp_dat_before_rst", rsp_dat, 32'h4242_4242);
        #2 rst = 1'b1;
        #1;
        chk("resp_discard", 32'(rsp_valid), 32'd0);
        chk("resp_dat_clr", rsp_dat, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("resp_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the maximum bus cycles to wait for wbm_ack_i before aborting (legal range 2..255).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: clock, all logic on rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_sel, input, 4 bits: byte selects.
REQ-008 SHALL have port cmd_adr, input, 32 bits: byte address.
REQ-009 SHALL have port cmd_dat, input, 32 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: response consumed when high together with rsp_valid.
REQ-012 SHALL have port rsp_dat, output, 32 bits: read data; 0 for writes and for aborted cycles.
REQ-013 SHALL have port rsp_err, output, 1 bit: 1 = timeout abort.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o, each an output of 1 bit, forming the Wishbone classic master controls.
REQ-015 SHALL have ports wbm_sel_o (output, 4 bits), wbm_adr_o (output, 32 bits) and wbm_dat_o (output, 32 bits).
REQ-016 SHALL have ports wbm_ack_i (input, 1 bit) and wbm_dat_i (input, 32 bits) carrying the slave response.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, BUS and RESP; all outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.
REQ-019 SHALL assert cmd_ready only in IDLE.
REQ-020 SHALL, on the edge where cmd_valid && cmd_ready, latch cmd_we, cmd_sel, cmd_adr and cmd_dat into wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o, set wbm_cyc_o = wbm_stb_o = 1, clear the wait counter to 1, and enter BUS.
REQ-021 SHALL hold wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o stable for the whole of BUS.
REQ-022 SHALL, in BUS, on an edge where wbm_ack_i = 1: capture wbm_dat_i into rsp_dat for a read or 0 for a write, set rsp_err = 0, drop wbm_cyc_o and wbm_stb_o, set rsp_valid = 1, and enter RESP.
REQ-023 SHALL, in BUS, on an edge where wbm_ack_i = 0 and the counter equals TIMEOUT: drop wbm_cyc_o and wbm_stb_o, set rsp_dat = 0, rsp_err = 1 and rsp_valid = 1, and enter RESP; wbm_cyc_o is therefore high for exactly TIMEOUT cycles.
REQ-024 SHALL, in BUS, increment the counter on every other edge; the counter SHALL be 8 bits wide and never wrap, given REQ-001.
REQ-025 SHALL give ack priority over timeout: an ack arriving on the TIMEOUT edge is a normal completion.
REQ-026 SHALL ignore wbm_ack_i and wbm_dat_i in IDLE and RESP, including late acks arriving after an abort.
REQ-027 SHALL hold rsp_valid, rsp_dat and rsp_err stable in RESP until rsp_ready = 1; on that edge it SHALL clear rsp_valid and enter IDLE, so cmd_ready is high on the following cycle.
REQ-028 SHALL keep one transaction outstanding at most; minimum command-to-command spacing is 3 cycles (accept, BUS with immediate ack, RESP with rsp_ready high).
REQ-029 SHALL allow wbm_sel_o = 0 and pass it through unmodified.

Reset
REQ-030 SHALL, while wb_rst_i = 1 (asynchronously), force state IDLE, all wbm_* outputs to 0, rsp_valid = 0, rsp_err = 0, rsp_dat = 0, counter = 0 and busy = 0; cmd_ready SHALL read 1 after release.
REQ-031 SHALL, when reset is asserted mid-BUS, drop wbm_cyc_o and wbm_stb_o immediately with no response produced; a pending response in RESP SHALL be discarded.

Verification
REQ-032 Write 0x3000_0004 / 0xA5A5_5A5A, sel 0xF, slave acks 12 cycles after stb -> wbm_we_o = 1, stable bus for 12 cycles, then rsp_valid = 1, rsp_dat = 0, rsp_err = 0.
REQ-033 Read 0x3800_0010, slave returns 0x1234_5678 with ack on the first BUS cycle -> rsp_dat = 0x1234_5678, rsp_err = 0, cyc high for 1 cycle.
REQ-034 Read with no ack, TIMEOUT = 64 -> cyc high for exactly 64 cycles, rsp_err = 1, rsp_dat = 0; a late ack on cycle 70 is ignored and cmd_ready stays correct.
REQ-035 Ack on exactly cycle 64 of BUS -> normal completion with rsp_err = 0.
REQ-036 rsp_ready held low for 20 cycles after a response, with cmd_valid held high -> cmd_ready stays 0 and the response is stable; the second command is accepted the cycle after the response is consumed.
REQ-037 wb_rst_i pulsed on cycle 5 of BUS -> cyc/stb go to 0 asynchronously, no rsp_valid, cmd_ready = 1 after release.
